fetch_axi_bridge: RTL and testbench
===================================

// Module: fetch_axi_bridge
// PURPOSE
//  Instruction-side bus bridge between the fetch controller's request/response handshakes
//  and an AXI4-Lite read channel (AR/R only). Accepts one PC per request and issues one AR beat.
//  Returns the fetched word, or a fault flag, through a registered response.
//  Strictly one outstanding transaction; sits directly below the fetch stage, above the IFU bus/arbiter.
// PARAMETERS
//  ADDR_W   32   address width; pc_i/araddr_o width
//  DATA_W   32   instruction/bus data width
//  CNT_W    32   width of saturating stall-cycle counter
// PORTS
//  reset             in   1       asynchronous, active-high reset
//  clock             in   1       single clock; all state on posedge
//  request_valid_i   in   1       fetch requests an instruction at pc_i
//  request_ready_o   out  1       bridge can accept a request (IDLE)
//  pc_i              in   ADDR_W  fetch address; sampled on request handshake
//  response_valid_o  out  1       inst_o/fault_o valid
//  response_ready_i  in   1       fetch consumes response
//  inst_o            out  DATA_W  fetched instruction (0 on fault)
//  fault_o           out  1       1 = misaligned PC or bus error
//  araddr_o          out  ADDR_W  AXI read address
//  arprot_o          out  3       constant 3'b100 (instruction, secure, unprivileged)
//  arvalid_o         out  1       AXI AR valid
//  arready_i         in   1       AXI AR ready
//  rdata_i           in   DATA_W  AXI read data
//  rresp_i           in   2       AXI read response
//  rvalid_i          in   1       AXI R valid
//  rready_o          out  1       AXI R ready
//  stall_cnt_o       out  CNT_W   cycles spent in ADDR+DATA, saturating at all-ones
// BEHAVIOUR
//  States: IDLE, ADDR, DATA, RESP; async reset -> IDLE.
//  Regs reset to 0: pc latch, inst, fault, stall count.
//  Outputs: request_ready_o = IDLE & ~reset; arvalid_o = ADDR; rready_o = DATA; response_valid_o = RESP.
//  araddr_o = latched pc at all times (0 after reset).
//  During reset all outputs are 0, except arprot_o = 3'b100.
//  IDLE: on request_valid_i, latch pc_i.
//   - pc_i[1:0]==0: -> ADDR.
//   - Otherwise no bus access: inst=0, fault=1, -> RESP.
//  ADDR: arvalid_o held high with stable araddr_o until arready_i; then -> DATA.
//   arready_i may be high before arvalid_o; handshake completes in the first ADDR cycle.
//  DATA: on rvalid_i, inst <= rdata_i and fault <= (rresp_i != 2'b00), -> RESP.
//   On fault, inst <= 0 instead of rdata_i.
//  RESP: hold inst_o/fault_o stable until response_ready_i, then -> IDLE.
//   No new request is accepted in the same cycle (request_ready_o low in RESP).
//  Latency: request handshake cycle N -> arvalid_o high in N+1.
//   R handshake cycle M -> response_valid_o high in M+1.
//   Minimum request-to-response is 3 cycles (arready and rvalid each in their first cycle).
//  arready_i is ignored outside ADDR; rvalid_i/rdata_i are ignored outside DATA.
//  request_valid_i is ignored outside IDLE.
//  stall_cnt_o increments once per cycle in ADDR or DATA and never wraps (sticks at 2^CNT_W-1).
//  It is cleared only by reset.
//  Reset mid-transaction: immediate return to IDLE with arvalid_o/rready_o low.
//   No response is produced for the aborted request.
//   The interconnect is reset by the same signal.
// TESTING
//  1. Reset release, req pc=0x8000_0000, arready=1 and rvalid=1 immediately, rdata=0x0000_0413, rresp=0
//     -> araddr 0x8000_0000; response_valid 3 cycles after the request; inst_o=0x0000_0413, fault_o=0.
//  2. arready held low 4 cycles -> arvalid stays 1 with araddr unchanged for 5 cycles.
//     rvalid low 3 cycles -> rready stays 1; stall_cnt_o advances by 5+4=9.
//  3. Req pc=0x8000_0002 -> no arvalid pulse; next cycle response_valid=1, fault_o=1, inst_o=0.
//  4. rresp=2'b10 (SLVERR) with rdata=0xDEAD_BEEF -> fault_o=1, inst_o=0.
//  5. response_ready low 5 cycles in RESP -> inst_o/fault_o stable, request_ready_o=0.
//     Then ready=1 -> request_ready_o=1 next cycle; back-to-back requests at pc, pc+4 fetch in order.
//  6. Assert reset asynchronously while in DATA -> arvalid_o/rready_o/response_valid_o drop without a clock edge.
//     After release: request_ready_o=1, stall_cnt_o=0, no spurious response.

Source files
------------

// File: rtl/fetch_axi_bridge_if.sv
// Signal bundle between the fetch stage, the bridge and the AXI4-Lite read channel.
// The bridge takes the master modport; the fetch/AXI side (or a bench) takes slave.
interface fetch_axi_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
);
    logic              request_valid_i;
    logic              request_ready_o;
    logic [ADDR_W-1:0] pc_i;
    logic              response_valid_o;
    logic              response_ready_i;
    logic [DATA_W-1:0] inst_o;
    logic              fault_o;
    logic [ADDR_W-1:0] araddr_o;
    logic [2:0]        arprot_o;
    logic              arvalid_o;
    logic              arready_i;
    logic [DATA_W-1:0] rdata_i;
    logic [1:0]        rresp_i;
    logic              rvalid_i;
    logic              rready_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        input  request_valid_i, pc_i, response_ready_i,
        input  arready_i, rdata_i, rresp_i, rvalid_i,
        output request_ready_o, response_valid_o, inst_o, fault_o,
        output araddr_o, arprot_o, arvalid_o, rready_o, stall_cnt_o
    );

    modport slave (
        output request_valid_i, pc_i, response_ready_i,
        output arready_i, rdata_i, rresp_i, rvalid_i,
        input  request_ready_o, response_valid_o, inst_o, fault_o,
        input  araddr_o, arprot_o, arvalid_o, rready_o, stall_cnt_o
    );
endinterface

// File: rtl/fetch_axi_bridge.sv
// Instruction fetch to AXI4-Lite read bridge: one outstanding AR/R transaction,
// registered response, misaligned-PC fault without a bus access, saturating stall counter.
module fetch_axi_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic clock,
    input  logic reset,
    fetch_axi_bridge_if.master bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [DATA_W-1:0] inst_reg, inst_next;
    logic              fault_reg, fault_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            pc_reg    <= '0;
            inst_reg  <= '0;
            fault_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            inst_reg  <= inst_next;
            fault_reg <= fault_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        inst_next  = inst_reg;
        fault_next = fault_reg;
        unique case (state_reg)
            IDLE: begin
                if (bus.request_valid_i) begin
                    pc_next = bus.pc_i;
                    if (bus.pc_i[1:0] == 2'b00) begin
                        state_next = ADDR;
                    end else begin
                        // Misaligned fetch is answered locally; the bus never sees it.
                        inst_next  = '0;
                        fault_next = 1'b1;
                        state_next = RESP;
                    end
                end
            end
            ADDR: begin
                if (bus.arready_i) state_next = DATA;
            end
            DATA: begin
                if (bus.rvalid_i) begin
                    fault_next = (bus.rresp_i != 2'b00);
                    inst_next  = (bus.rresp_i != 2'b00) ? '0 : bus.rdata_i;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (bus.response_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Counts bus wait cycles; pins at all-ones instead of wrapping.
    always_comb begin
        cnt_next = cnt_reg;
        if (((state_reg == ADDR) || (state_reg == DATA)) && (cnt_reg != {CNT_W{1'b1}}))
            cnt_next = cnt_reg + 1'b1;
    end

    assign bus.request_ready_o  = (state_reg == IDLE) & ~reset;
    assign bus.arvalid_o        = (state_reg == ADDR) & ~reset;
    assign bus.rready_o         = (state_reg == DATA) & ~reset;
    assign bus.response_valid_o = (state_reg == RESP) & ~reset;
    assign bus.araddr_o         = pc_reg;
    assign bus.arprot_o         = 3'b100;
    assign bus.inst_o           = inst_reg;
    assign bus.fault_o          = fault_reg;
    assign bus.stall_cnt_o      = cnt_reg;
endmodule

// File: tb/tb_fetch_axi_bridge.sv
// Directed bench for fetch_axi_bridge: one task per scenario, inline checks, one summary line.
module tb_fetch_axi_bridge;
    logic clock;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    fetch_axi_bridge_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(32)) bus ();

    fetch_axi_bridge #(.ADDR_W(32), .DATA_W(32), .CNT_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.request_valid_i  = 1'b0;
        bus.pc_i             = '0;
        bus.response_ready_i = 1'b0;
        bus.arready_i        = 1'b0;
        bus.rdata_i          = '0;
        bus.rresp_i          = 2'b00;
        bus.rvalid_i         = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        total_cnt++; if (bus.request_ready_o !== 1'b0) $display("FAIL rst_req_ready got %b want 0", bus.request_ready_o); else pass_cnt++;
        total_cnt++; if (bus.arvalid_o !== 1'b0) $display("FAIL rst_arvalid got %b want 0", bus.arvalid_o); else pass_cnt++;
        total_cnt++; if (bus.rready_o !== 1'b0) $display("FAIL rst_rready got %b want 0", bus.rready_o); else pass_cnt++;
        total_cnt++; if (bus.response_valid_o !== 1'b0) $display("FAIL rst_resp_valid got %b want 0", bus.response_valid_o); else pass_cnt++;
        total_cnt++; if (bus.arprot_o !== 3'b100) $display("FAIL rst_arprot got %b want 100", bus.arprot_o); else pass_cnt++;
        total_cnt++; if (bus.araddr_o !== 32'h0) $display("FAIL rst_araddr got %h want 0", bus.araddr_o); else pass_cnt++;
        total_cnt++; if (bus.stall_cnt_o !== 32'd0) $display("FAIL rst_stall got %0d want 0", bus.stall_cnt_o); else pass_cnt++;
        total_cnt++; if ({bus.inst_o, bus.fault_o} !== 33'h0) $display("FAIL rst_inst_fault got %h/%b want 0/0", bus.inst_o, bus.fault_o); else pass_cnt++;
        reset = 1'b0;
        tick();
        total_cnt++; if (bus.request_ready_o !== 1'b1) $display("FAIL rel_req_ready got %b want 1", bus.request_ready_o); else pass_cnt++;
        $display("reset: done");
    endtask

    task automatic test_basic();
        bus.arready_i = 1'b1;
        bus.rvalid_i  = 1'b1;
        bus.rdata_i   = 32'h0000_0413;
        bus.rresp_i   = 2'b00;
        bus.request_valid_i = 1'b1;
        bus.pc_i            = 32'h8000_0000;
        tick();
        bus.request_valid_i = 1'b0;
        total_cnt++; if (bus.arvalid_o !== 1'b1) $display("FAIL basic_arvalid got %b want 1", bus.arvalid_o); else pass_cnt++;
        total_cnt++; if (bus.araddr_o !== 32'h8000_0000) $display("FAIL basic_araddr got %h want 80000000", bus.araddr_o); else pass_cnt++;
        total_cnt++; if (bus.request_ready_o !== 1'b0) $display("FAIL basic_req_busy got %b want 0", bus.request_ready_o); else pass_cnt++;
        tick();
        total_cnt++; if (bus.rready_o !== 1'b1) $display("FAIL basic_rready got %b want 1", bus.rready_o); else pass_cnt++;
        total_cnt++; if (bus.response_valid_o !== 1'b0) $display("FAIL basic_resp_early got %b want 0", bus.response_valid_o); else pass_cnt++;
        tick();
        total_cnt++; if (bus.response_valid_o !== 1'b1) $display("FAIL basic_resp_valid got %b want 1", bus.response_valid_o); else pass_cnt++;
        total_cnt++; if (bus.inst_o !== 32'h0000_0413) $display("FAIL basic_inst got %h want 00000413", bus.inst_o); else pass_cnt++;
        total_cnt++; if (bus.fault_o !== 1'b0) $display("FAIL basic_fault got %b want 0", bus.fault_o); else pass_cnt++;
        total_cnt++; if (bus.stall_cnt_o !== 32'd2) $display("FAIL basic_stall got %0d want 2", bus.stall_cnt_o); else pass_cnt++;
        bus.response_ready_i = 1'b1;
        tick();
        bus.response_ready_i = 1'b0;
        total_cnt++; if (bus.request_ready_o !== 1'b1) $display("FAIL basic_idle got %b want 1", bus.request_ready_o); else pass_cnt++;
        $display("basic: pc=80000000 inst=%h fault=%b", bus.inst_o, bus.fault_o);
    endtask

    task automatic test_stall();
        bus.arready_i = 1'b0;
        bus.rvalid_i  = 1'b0;
        bus.request_valid_i = 1'b1;
        bus.pc_i            = 32'h8000_0004;
        tick();
        bus.request_valid_i = 1'b0;
        bus.pc_i            = 32'hFFFF_FFF0;
        for (int i = 0; i < 5; i++) begin
            total_cnt++; if (bus.arvalid_o !== 1'b1 || bus.araddr_o !== 32'h8000_0004)
                $display("FAIL stall_ar[%0d] got %b/%h want 1/80000004", i, bus.arvalid_o, bus.araddr_o); else pass_cnt++;
            if (i == 4) bus.arready_i = 1'b1;
            tick();
        end
        bus.arready_i = 1'b0;
        bus.rdata_i   = 32'h00A0_0093;
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if (bus.rready_o !== 1'b1 || bus.response_valid_o !== 1'b0)
                $display("FAIL stall_r[%0d] got %b/%b want 1/0", i, bus.rready_o, bus.response_valid_o); else pass_cnt++;
            if (i == 3) bus.rvalid_i = 1'b1;
            tick();
        end
        bus.rvalid_i = 1'b0;
        total_cnt++; if (bus.response_valid_o !== 1'b1 || bus.inst_o !== 32'h00A0_0093)
            $display("FAIL stall_resp got %b/%h want 1/00a00093", bus.response_valid_o, bus.inst_o); else pass_cnt++;
        total_cnt++; if (bus.stall_cnt_o !== 32'd11) $display("FAIL stall_cnt got %0d want 11", bus.stall_cnt_o); else pass_cnt++;
        bus.response_ready_i = 1'b1;
        tick();
        bus.response_ready_i = 1'b0;
        $display("stall: inst=%h stall_cnt=%0d", bus.inst_o, bus.stall_cnt_o);
    endtask

    task automatic test_misaligned();
        bus.arready_i = 1'b1;
        bus.request_valid_i = 1'b1;
        bus.pc_i            = 32'h8000_0002;
        tick();
        bus.request_valid_i = 1'b0;
        total_cnt++; if (bus.arvalid_o !== 1'b0) $display("FAIL mis_arvalid got %b want 0", bus.arvalid_o); else pass_cnt++;
        total_cnt++; if (bus.response_valid_o !== 1'b1) $display("FAIL mis_resp_valid got %b want 1", bus.response_valid_o); else pass_cnt++;
        total_cnt++; if (bus.fault_o !== 1'b1 || bus.inst_o !== 32'h0)
            $display("FAIL mis_fault got %b/%h want 1/0", bus.fault_o, bus.inst_o); else pass_cnt++;
        total_cnt++; if (bus.stall_cnt_o !== 32'd11) $display("FAIL mis_stall got %0d want 11", bus.stall_cnt_o); else pass_cnt++;
        bus.response_ready_i = 1'b1;
        tick();
        bus.response_ready_i = 1'b0;
        $display("misaligned: pc=80000002 fault=%b", bus.fault_o);
    endtask

    task automatic test_slverr_hold();
        bus.arready_i = 1'b1;
        bus.rvalid_i  = 1'b1;
        bus.rresp_i   = 2'b10;
        bus.rdata_i   = 32'hDEAD_BEEF;
        bus.request_valid_i = 1'b1;
        bus.pc_i            = 32'h8000_0008;
        tick();
        bus.request_valid_i = 1'b0;
        tick();
        tick();
        bus.rresp_i = 2'b00;
        total_cnt++; if (bus.response_valid_o !== 1'b1 || bus.fault_o !== 1'b1 || bus.inst_o !== 32'h0)
            $display("FAIL slverr got %b/%b/%h want 1/1/0", bus.response_valid_o, bus.fault_o, bus.inst_o); else pass_cnt++;
        // Hold the response back while a stray request is presented.
        bus.request_valid_i = 1'b1;
        bus.pc_i            = 32'h0000_1234;
        for (int i = 0; i < 5; i++) begin
            total_cnt++; if (bus.response_valid_o !== 1'b1 || bus.fault_o !== 1'b1 || bus.inst_o !== 32'h0 ||
                             bus.request_ready_o !== 1'b0 || bus.araddr_o !== 32'h8000_0008)
                $display("FAIL hold[%0d] got v=%b f=%b i=%h rr=%b a=%h want 1/1/0/0/80000008",
                         i, bus.response_valid_o, bus.fault_o, bus.inst_o, bus.request_ready_o, bus.araddr_o);
            else pass_cnt++;
            tick();
        end
        bus.request_valid_i  = 1'b0;
        bus.response_ready_i = 1'b1;
        tick();
        bus.response_ready_i = 1'b0;
        total_cnt++; if (bus.request_ready_o !== 1'b1 || bus.response_valid_o !== 1'b0)
            $display("FAIL hold_release got %b/%b want 1/0", bus.request_ready_o, bus.response_valid_o); else pass_cnt++;
        total_cnt++; if (bus.stall_cnt_o !== 32'd13) $display("FAIL slverr_stall got %0d want 13", bus.stall_cnt_o); else pass_cnt++;
        $display("slverr_hold: fault=%b inst=%h", bus.fault_o, bus.inst_o);
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs  [2];
        logic [31:0] data [2];
        pcs[0] = 32'h8000_0100; data[0] = 32'h1111_1113;
        pcs[1] = 32'h8000_0104; data[1] = 32'h2222_2213;
        bus.arready_i = 1'b1;
        bus.rvalid_i  = 1'b1;
        bus.rresp_i   = 2'b00;
        for (int i = 0; i < 2; i++) begin
            bus.rdata_i         = data[i];
            bus.request_valid_i = 1'b1;
            bus.pc_i            = pcs[i];
            tick();
            bus.request_valid_i = 1'b0;
            total_cnt++; if (bus.araddr_o !== pcs[i]) $display("FAIL b2b_araddr[%0d] got %h want %h", i, bus.araddr_o, pcs[i]); else pass_cnt++;
            tick();
            tick();
            total_cnt++; if (bus.response_valid_o !== 1'b1 || bus.inst_o !== data[i] || bus.fault_o !== 1'b0)
                $display("FAIL b2b_resp[%0d] got %b/%h/%b want 1/%h/0", i, bus.response_valid_o, bus.inst_o, bus.fault_o, data[i]);
            else pass_cnt++;
            $display("b2b[%0d]: pc=%h inst=%h", i, pcs[i], bus.inst_o);
            bus.response_ready_i = 1'b1;
            tick();
            bus.response_ready_i = 1'b0;
        end
        total_cnt++; if (bus.stall_cnt_o !== 32'd17) $display("FAIL b2b_stall got %0d want 17", bus.stall_cnt_o); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        bus.arready_i = 1'b1;
        bus.rvalid_i  = 1'b0;
        bus.request_valid_i = 1'b1;
        bus.pc_i            = 32'h8000_0200;
        tick();
        bus.request_valid_i = 1'b0;
        tick();
        total_cnt++; if (bus.rready_o !== 1'b1) $display("FAIL ar_in_data got %b want 1", bus.rready_o); else pass_cnt++;
        #2;
        reset = 1'b1;
        #1;
        total_cnt++; if ({bus.arvalid_o, bus.rready_o, bus.response_valid_o, bus.request_ready_o} !== 4'b0000)
            $display("FAIL ar_async got %b%b%b%b want 0000", bus.arvalid_o, bus.rready_o, bus.response_valid_o, bus.request_ready_o);
        else pass_cnt++;
        bus.rvalid_i = 1'b1;
        bus.rdata_i  = 32'h5555_5555;
        tick();
        reset = 1'b0;
        tick();
        total_cnt++; if (bus.request_ready_o !== 1'b1 || bus.stall_cnt_o !== 32'd0)
            $display("FAIL ar_release got rr=%b cnt=%0d want 1/0", bus.request_ready_o, bus.stall_cnt_o); else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if (bus.response_valid_o !== 1'b0) $display("FAIL ar_spurious[%0d] got %b want 0", i, bus.response_valid_o); else pass_cnt++;
            tick();
        end
        bus.rvalid_i = 1'b0;
        $display("async_reset: request_ready=%b stall_cnt=%0d", bus.request_ready_o, bus.stall_cnt_o);
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset     = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_misaligned();
        test_slverr_hold();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
